// File: rtl/local_spike_receiver.sv
// local_spike_receiver: reassembles 4-bit router flits MSB-first into 32-bit spike packets queued in a FIFO; LOCAL_RX_DROP_CNT_EN compiles in drop_cnt
module local_spike_receiver #(
  parameter int axon_number_bit_width = 1,
  parameter int FIFO_DEPTH = 2,
  parameter int flit_size = 4,
  parameter int packet_size = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [flit_size-1:0]             flit_in,
  input  logic                             write_req,
  output logic                             full,
  output logic                             spike_valid,
  input  logic                             spike_ready,
  output logic [31:0]                      spike_packet,
  output logic [axon_number_bit_width-1:0] spike_axon,
  output logic [7:0]                       drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [2:0] cnt;
  logic [packet_size-flit_size-1:0] shreg;
  logic [packet_size-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic accept, push, pop;
  assign full = occ == (AW+1)'(FIFO_DEPTH);
  assign spike_valid = occ != '0;
  assign accept = write_req & ~full;
  assign push = accept & (cnt == 3'd7);
  assign pop = spike_valid & spike_ready;
  assign spike_packet = spike_valid ? mem[rd_ptr] : '0;
  assign spike_axon = spike_packet[axon_number_bit_width-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      shreg <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      if (accept) begin
        cnt <= cnt + 3'd1;
        shreg <= {shreg[packet_size-2*flit_size-1:0], flit_in};
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {shreg, flit_in};
`ifdef LOCAL_RX_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) drop_cnt <= '0;
    else if (write_req && full && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_local_spike_receiver.sv
// tb_local_spike_receiver: directed stimulus checked every cycle against a queue-based packet model plus literal expectations
module tb_local_spike_receiver;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 1, write_req = 0, spike_ready = 0;
  logic [3:0] flit_in = 0;
  logic full, spike_valid;
  logic [31:0] spike_packet;
  logic [0:0] spike_axon;
  logic [7:0] drop_cnt;
  int errors = 0, checks = 0;
  logic [31:0] q[$];
  logic [31:0] seen[$];
  logic [31:0] part;
  int nflits, mdrop;
  local_spike_receiver #(.axon_number_bit_width(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flit_in(flit_in), .write_req(write_req), .full(full),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_packet(spike_packet),
    .spike_axon(spike_axon), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    part = 0;
    nflits = 0;
    mdrop = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        part = 0;
        nflits = 0;
        mdrop = 0;
      end else begin
        automatic bit mfull = q.size() == DEPTH;
        if (q.size() != 0 && spike_ready) void'(q.pop_front());
        if (write_req && mfull) begin
`ifdef LOCAL_RX_DROP_CNT_EN
          if (mdrop < 255) mdrop++;
`endif
        end else if (write_req) begin
          part = {part[27:0], flit_in};
          nflits++;
          if (nflits == 8) begin
            q.push_back(part);
            nflits = 0;
          end
        end
      end
    end
  end
  always @(posedge clk)
    if (!reset && spike_valid && spike_ready) seen.push_back(spike_packet);
  always @(negedge clk) begin
    chk("model_valid", {31'b0, spike_valid}, {31'b0, q.size() != 0});
    chk("model_full", {31'b0, full}, {31'b0, q.size() == DEPTH});
    chk("model_packet", spike_packet, q.size() != 0 ? q[0] : 32'h0);
    chk("model_axon", {31'b0, spike_axon}, q.size() != 0 ? {31'b0, q[0][0]} : 32'h0);
    chk("model_drop", {24'b0, drop_cnt}, mdrop);
  end
  task automatic send(input logic [3:0] f);
    bit acc = 0;
    flit_in = f;
    write_req = 1;
    for (int i = 0; i < 300; i++) begin
      acc = !full;
      @(negedge clk);
      if (acc) break;
    end
    write_req = 0;
    if (!acc) chk("send_timeout", 32'd1, 32'd0);
  endtask
  task automatic send_pkt(input logic [31:0] p, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send(p[i*4 +: 4]);
      repeat (gap) @(negedge clk);
    end
  endtask
  task automatic drain;
    spike_ready = 1;
    for (int i = 0; i < 50 && spike_valid; i++) @(negedge clk);
    @(negedge clk);
    spike_ready = 0;
  endtask
  task automatic do_reset;
    reset = 1;
    @(negedge clk);
    chk("rst_valid", {31'b0, spike_valid}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_packet", spike_packet, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    reset = 0;
    @(negedge clk);
    seen.delete();
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    spike_ready = 1;
    send_pkt(32'h12345678, 0);
    chk("basic_valid", {31'b0, spike_valid}, 32'd1);
    chk("basic_packet", spike_packet, 32'h12345678);
    chk("basic_axon", {31'b0, spike_axon}, 32'd0);
    @(negedge clk);
    chk("basic_one_cycle", {31'b0, spike_valid}, 32'd0);
    spike_ready = 0;
    send_pkt(32'hA5C39E17, 3);
    repeat (4) @(negedge clk);
    chk("gap_packet", spike_packet, 32'hA5C39E17);
    chk("gap_axon", {31'b0, spike_axon}, 32'd1);
    drain();
    seen.delete();
    send_pkt(32'h0000AAAA, 0);
    send_pkt(32'hBBBB0001, 0);
    chk("bp_full", {31'b0, full}, 32'd1);
    fork
      send_pkt(32'hCCCC5555, 0);
      begin
        repeat (6) @(negedge clk);
        chk("bp_still_a", spike_packet, 32'h0000AAAA);
        spike_ready = 1;
      end
    join
    drain();
    chk("bp_count", seen.size(), 32'd3);
    if (seen.size() == 3) begin
      chk("bp_a", seen[0], 32'h0000AAAA);
      chk("bp_b", seen[1], 32'hBBBB0001);
      chk("bp_c", seen[2], 32'hCCCC5555);
    end
    do_reset();
    send_pkt(32'h11111111, 0);
    send_pkt(32'h22222222, 0);
    write_req = 1;
    flit_in = 4'h9;
    repeat (10) @(negedge clk);
    write_req = 0;
`ifdef LOCAL_RX_DROP_CNT_EN
    chk("drop_10", {24'b0, drop_cnt}, 32'd10);
`else
    chk("drop_10", {24'b0, drop_cnt}, 32'd0);
`endif
    write_req = 1;
    repeat (250) @(negedge clk);
    write_req = 0;
`ifdef LOCAL_RX_DROP_CNT_EN
    chk("drop_sat", {24'b0, drop_cnt}, 32'd255);
`else
    chk("drop_sat", {24'b0, drop_cnt}, 32'd0);
`endif
    drain();
    for (int i = 0; i < 5; i++) send(4'hF);
    do_reset();
    send_pkt(32'hCAFEF00D, 0);
    chk("rst_mid_packet", spike_packet, 32'hCAFEF00D);
    drain();
    chk("rst_mid_count", seen.size(), 32'd1);
    seen.delete();
    send_pkt(32'h13572468, 0);
    for (int i = 7; i >= 1; i--) send(4'(i));
    flit_in = 4'h0;
    write_req = 1;
    spike_ready = 1;
    @(negedge clk);
    write_req = 0;
    spike_ready = 0;
    chk("same_edge_full", {31'b0, full}, 32'd0);
    chk("same_edge_valid", {31'b0, spike_valid}, 32'd1);
    chk("same_edge_packet", spike_packet, 32'h76543210);
    drain();
    chk("same_edge_count", seen.size(), 32'd2);
    if (seen.size() == 2) begin
      chk("same_edge_first", seen[0], 32'h13572468);
      chk("same_edge_second", seen[1], 32'h76543210);
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/local_spike_receiver.md
LOCAL_SPIKE_RECEIVER -- requirements
Module: local_spike_receiver

Interface
REQ-001 SHALL have parameter axon_number_bit_width, default 1, giving the width of the decoded axon index.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, giving the number of assembled packets buffered (power of 2, >=2).
REQ-003 SHALL have parameter flit_size, fixed at 4, and packet_size, fixed at 32, so 8 flits form one packet.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port flit_in, input, [flit_size-1:0]: flit from the router local output.
REQ-007 SHALL have port write_req, input, 1 bit: router asserts it for each flit presented.
REQ-008 SHALL have port full, output, 1 bit: backpressure to the router's local_neuron_full input.
REQ-009 SHALL have port spike_valid, output, 1 bit: head-of-FIFO packet is available.
REQ-010 SHALL have port spike_ready, input, 1 bit: neuron consumes the head packet.
REQ-011 SHALL have port spike_packet, output, [31:0]: head packet, fully reassembled.
REQ-012 SHALL have port spike_axon, output, [axon_number_bit_width-1:0]: equal to spike_packet[axon_number_bit_width-1:0].
REQ-013 SHALL have port drop_cnt, output, [7:0]: count of flits dropped while full.

Function
REQ-014 SHALL accept a flit on a clk edge when write_req=1 and full=0.
REQ-015 SHALL assemble flits MSB-first: first flit -> packet[31:28], eighth flit -> packet[3:0].
REQ-016 SHALL track position with a 3-bit flit counter that counts 0..7 and wraps to 0 on the eighth flit.
REQ-017 SHALL, on the edge accepting the eighth flit, write the complete 32-bit word (shift register plus flit_in) into the FIFO; spike_valid rises the following cycle if the FIFO was empty.
REQ-018 SHALL assert full combinationally when the FIFO holds FIFO_DEPTH packets; while full, no flit of any position is accepted, even mid-packet.
REQ-019 SHALL pop the head on an edge where spike_valid=1 and spike_ready=1; spike_packet/spike_axon are held stable while spike_valid=1 and spike_ready=0.
REQ-020 SHALL allow push and pop on the same edge when the FIFO is neither empty-on-pop nor full-on-push, leaving occupancy unchanged.
REQ-021 SHALL handle the FIFO read/write pointer wrap at FIFO_DEPTH without losing or duplicating packets.
REQ-022 SHALL ignore flit_in when write_req=0; the partial packet and counter are held indefinitely between flits.

Reset
REQ-023 SHALL, on reset=1 asynchronously, clear flit counter, shift register, FIFO pointers and occupancy, and drop_cnt.
REQ-024 SHALL drive full=0, spike_valid=0, spike_packet=0, spike_axon=0, drop_cnt=0 during and after reset.
REQ-025 SHALL discard any partial packet and all buffered packets on reset mid-operation; the next accepted flit is treated as flit 0.

Configuration
REQ-026 SHALL use the macro LOCAL_RX_DROP_CNT_EN to compile the drop counter in or out.
REQ-027 SHALL, with LOCAL_RX_DROP_CNT_EN defined, increment drop_cnt on each edge with write_req=1 and full=1, saturating at 255.
REQ-028 SHALL, without LOCAL_RX_DROP_CNT_EN, tie drop_cnt to 0 with no counter logic; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover this case: flits 1,2,3,4,5,6,7,8 on consecutive edges, spike_ready=1 -> spike_valid for exactly one cycle, one cycle after the 8th edge, spike_packet=32'h12345678, spike_axon=0 (width 1).
REQ-030 SHALL cover this case: three packets A,B,C sent back-to-back with spike_ready=0 and depth 2 -> full=1 after B completes; C is stalled; raising spike_ready pops A then B, and C is accepted and delivered intact.
REQ-031 SHALL cover this case: a packet sent with write_req gaps of 3 idle cycles between flits -> packet reassembles correctly, value unchanged.
REQ-032 SHALL cover this case: reset pulsed after 5 flits, then 8 flits of 32'hCAFEF00D -> output is exactly 32'hCAFEF00D and no remnant of the first partial packet appears.
REQ-033 SHALL cover this case: FIFO full and write_req=1 held for 10 cycles, macro defined -> drop_cnt=10; macro undefined -> drop_cnt=0.
REQ-034 SHALL cover this case: with FIFO at depth-1, the eighth flit arrives on the same edge as a pop -> occupancy stays depth-1, full stays 0, order is preserved.
